// File: rtl/restador8b.sv
// Loadable down-counter with IDLE/RUN/DONE control and a one-cycle terminal pulse on bout.
// Define RESTADOR8B_AUTORELOAD_EN for periodic mode: the last loaded value is reloaded at terminal count.
module restador8b #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             bout,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_next_s;
   logic [WIDTH-1:0] out_r;
   logic [WIDTH-1:0] count_next_s;
   logic [WIDTH-1:0] term_value_s;
   state_t           term_state_s;
   logic             bout_r;
   logic             bout_next_s;
   logic             busy_r;

`ifdef RESTADOR8B_AUTORELOAD_EN
   logic [WIDTH-1:0] reload_r;

   // Remember every loaded value so the terminal count can restart the period
   always_ff @(posedge clk) begin
      if (rst) begin
         reload_r <= ZERO;
      end else if (load) begin
         reload_r <= load_val;
      end else begin
         reload_r <= reload_r;
      end
   end

   assign term_value_s = reload_r;
   assign term_state_s = RUN;
`else
   assign term_value_s = ZERO;
   assign term_state_s = DONE;
`endif

   // Next-state and next-count: load wins over counting; only RUN reacts to enable
   always_comb begin
      state_next_s = state_r;
      count_next_s = out_r;
      bout_next_s  = 1'b0;
      if (load) begin
         count_next_s = load_val;
         if (load_val != ZERO) begin
            state_next_s = RUN;
         end else begin
            state_next_s = IDLE;
         end
      end else begin
         case (state_r)
            RUN: begin
               if (enable) begin
                  if (out_r == ONE) begin
                     count_next_s = term_value_s;
                     bout_next_s  = 1'b1;
                     state_next_s = term_state_s;
                  end else begin
                     count_next_s = out_r - ONE;
                  end
               end else begin
                  count_next_s = out_r;
               end
            end
            IDLE: begin
               state_next_s = IDLE;
            end
            DONE: begin
               state_next_s = DONE;
            end
            default: begin
               // Unreachable encoding: recover to a safe idle, cleared counter
               state_next_s = IDLE;
               count_next_s = ZERO;
            end
         endcase
      end
   end

   // Register state and every output so nothing reaches a port combinationally
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         out_r   <= ZERO;
         bout_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         out_r   <= count_next_s;
         bout_r  <= bout_next_s;
         busy_r  <= (state_next_s == RUN);
      end
   end

   assign out  = out_r;
   assign bout = bout_r;
   assign busy = busy_r;

endmodule

// File: doc/restador8b.md
RESTADOR8B -- requirements
Module: restador8b

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and load-value width in bits.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port enable, input, 1, count-down qualifier.
REQ-005 SHALL have port load, input, 1, one-cycle request to load load_val.
REQ-006 SHALL have port load_val, input, WIDTH, start value captured on load.
REQ-007 SHALL have port out, output, WIDTH, registered current count.
REQ-008 SHALL have port bout, output, 1, registered borrow/terminal pulse, complement of the adder's cout.
REQ-009 SHALL have port busy, output, 1, high while in state RUN.

Function
REQ-010 SHALL implement states IDLE, RUN and DONE; busy = 1 only in RUN.
REQ-011 load=1, any state, load_val!=0: next cycle out=load_val, state RUN, bout=0.
REQ-012 load=1 with load_val=0: next cycle out=0, state IDLE, bout=0, no terminal pulse.
REQ-013 RUN, enable=1, load=0, out>1: next cycle out=out-1 (modulo 2^WIDTH not reachable).
REQ-014 RUN, enable=1, load=0, out=1: next cycle out=0, bout=1 for exactly that cycle, state DONE.
REQ-015 RUN, enable=0, load=0: out, state held; bout=0.
REQ-016 IDLE or DONE, load=0: out held (no decrement, no wrap 0->all-ones), bout=0, enable ignored.
REQ-017 load SHALL take priority over enable; simultaneous load and terminal decrement: load applied, bout=0.
REQ-018 bout SHALL be a single-cycle pulse; never high two consecutive cycles unless REQ-023 reload with load_val=1.
REQ-019 Load latency 1 cycle; decrement latency 1 cycle; no combinational path from inputs to outputs.

Reset
REQ-020 rst=1 at a rising edge SHALL force out=0, bout=0, busy=0, state IDLE, stored reload value=0.
REQ-021 rst SHALL override load and enable in the same cycle, including mid-count in RUN.

Configuration
REQ-022 Macro RESTADOR8B_AUTORELOAD_EN SHALL select periodic mode; undefined = one-shot (REQ-014 to DONE).
REQ-023 With macro: load_val captured into reload register on load; at terminal (out=1, enable=1) out=reload value, bout=1, state stays RUN, DONE unreachable.
REQ-024 Without macro: no reload register implemented; behaviour exactly REQ-010..REQ-019.

Verification
REQ-025 rst=1 two cycles, then load=0, enable=1 -> out=0x00, bout=0, busy=0 held.
REQ-026 load 0x03, then enable=1 -> out 0x03,0x02,0x01,0x00; bout=1 only with out=0x00; busy falls same cycle; then holds 0x00 (one-shot).
REQ-027 load 0x05, enable toggled 1,0,1 -> out 0x05,0x04,0x04,0x03; bout=0 throughout.
REQ-028 out=0x01 in RUN, load=1 load_val=0x10 and enable=1 same cycle -> out=0x10, bout=0, busy=1.
REQ-029 mid-count out=0x7A, rst=1 with load=1 -> out=0x00, state IDLE, busy=0, bout=0.
REQ-030 with RESTADOR8B_AUTORELOAD_EN, load 0x02, enable=1 -> out 0x02,0x01,0x02,0x01,...; bout=1 each cycle out returns to 0x02; busy stays 1.
